// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: register map, FSM states
// and the readback status byte layout.
package pwm_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_TARGET    = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_STEP      = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE  = 7'h07;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 7'h08;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  function automatic logic [DATA_W-1:0] status_byte(input logic done_sticky,
                                                    input logic busy);
    return {6'b000000, done_sticky, busy};
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_ramp_tick_gen.sv
// Ramp rate divider: emits a one-cycle tick every prescale+1 active cycles.
// The counter restarts on clear and idles at zero while inactive.
module ramp_tick_gen
  import pwm_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  active,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] count_r;

  // Compared against the live prescale so a rewrite takes effect immediately;
  // a counter already beyond the new prescale simply wraps around.
  assign tick = active && !clear && (count_r == prescale);

  // Prescale counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (clear || !active || tick) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Register bank and duty ramp sequencer feeding the PWM peripheral.
// Optional readback port and sticky done flag: define PWM_RAMP_STATUS_EN.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
`ifdef PWM_RAMP_STATUS_EN
  input  logic [6:0]        rd_addr,
  output logic [7:0]        rd_data,
`endif
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [DUTY_W-1:0] pwm_duty_cycle,
  output logic              ramp_busy,
  output logic              ramp_done
);

  localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};

  ramp_state_e state_r, state_next_s;

  logic [7:0]            en_out_lo_r, en_out_hi_r, en_pwm_lo_r, en_pwm_hi_r;
  logic [DUTY_W-1:0]     duty_r, target_r, step_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  done_r;

  logic [DUTY_W-1:0] duty_next_s, target_next_s;
  logic              done_next_s;
  logic              cnt_clear_s;
  logic              tick_s;

  logic              duty_wr_s, target_wr_s;
  logic [DUTY_W-1:0] wr_val_s;
  logic [DUTY_W-1:0] eff_target_s, eff_step_s, gap_s, stepped_s;

  assign duty_wr_s   = wr_valid && (wr_addr == ADDR_DUTY);
  assign target_wr_s = wr_valid && (wr_addr == ADDR_TARGET);
  assign wr_val_s    = wr_data[DUTY_W-1:0];

  ramp_tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_r == RAMP),
    .clear   (cnt_clear_s),
    .prescale(prescale_r),
    .tick    (tick_s)
  );

  // Step arithmetic toward the effective target (a same-cycle retarget wins), clamped so it never overshoots.
  always_comb begin
    eff_target_s = target_r;
    eff_step_s   = step_r;
    gap_s        = DUTY_ZERO;
    stepped_s    = duty_r;
    if (target_wr_s) begin
      eff_target_s = wr_val_s;
    end else begin
      eff_target_s = target_r;
    end
    if (step_r == DUTY_ZERO) begin
      eff_step_s = DUTY_ONE;
    end else begin
      eff_step_s = step_r;
    end
    if (eff_target_s > duty_r) begin
      gap_s = eff_target_s - duty_r;
      if (gap_s <= eff_step_s) begin
        stepped_s = eff_target_s;
      end else begin
        stepped_s = duty_r + eff_step_s;
      end
    end else if (eff_target_s < duty_r) begin
      gap_s = duty_r - eff_target_s;
      if (gap_s <= eff_step_s) begin
        stepped_s = eff_target_s;
      end else begin
        stepped_s = duty_r - eff_step_s;
      end
    end else begin
      stepped_s = duty_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (target_wr_s && (wr_val_s != duty_r)) begin
          state_next_s = RAMP;
        end else begin
          state_next_s = IDLE;
        end
      end
      RAMP: begin
        if (duty_wr_s) begin
          state_next_s = IDLE;
        end else if (target_wr_s && (wr_val_s == duty_r)) begin
          state_next_s = IDLE;
        end else if (tick_s && (stepped_s == eff_target_s)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RAMP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: next duty/target, done pulse and counter restart.
  always_comb begin
    duty_next_s   = duty_r;
    target_next_s = target_r;
    done_next_s   = 1'b0;
    cnt_clear_s   = 1'b0;
    if (duty_wr_s) begin
      duty_next_s   = wr_val_s;
      target_next_s = wr_val_s;
    end else if (target_wr_s) begin
      target_next_s = wr_val_s;
      if (wr_val_s == duty_r) begin
        done_next_s = 1'b1;
      end else if (state_r == IDLE) begin
        cnt_clear_s = 1'b1;
      end else if (tick_s) begin
        duty_next_s = stepped_s;
        done_next_s = (stepped_s == wr_val_s);
      end else begin
        duty_next_s = duty_r;
      end
    end else if ((state_r == RAMP) && tick_s) begin
      duty_next_s = stepped_s;
      done_next_s = (stepped_s == target_r);
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Duty datapath and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r   <= DUTY_ZERO;
      target_r <= DUTY_ZERO;
      done_r   <= 1'b0;
    end else begin
      duty_r   <= duty_next_s;
      target_r <= target_next_s;
      done_r   <= done_next_s;
    end
  end

  // Plain configuration registers; none of these disturb an active ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo_r <= 8'h00;
      en_out_hi_r <= 8'h00;
      en_pwm_lo_r <= 8'h00;
      en_pwm_hi_r <= 8'h00;
      step_r      <= DUTY_ONE;
      prescale_r  <= PRE_ZERO;
    end else if (wr_valid) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: en_out_lo_r <= wr_data;
        ADDR_EN_OUT_HI: en_out_hi_r <= wr_data;
        ADDR_EN_PWM_LO: en_pwm_lo_r <= wr_data;
        ADDR_EN_PWM_HI: en_pwm_hi_r <= wr_data;
        ADDR_STEP:      step_r      <= wr_data[DUTY_W-1:0];
        ADDR_PRESCALE:  prescale_r  <= wr_data[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = en_out_lo_r;
  assign en_reg_out_15_8 = en_out_hi_r;
  assign en_reg_pwm_7_0  = en_pwm_lo_r;
  assign en_reg_pwm_15_8 = en_pwm_hi_r;
  assign pwm_duty_cycle  = duty_r;
  assign ramp_busy       = (state_r == RAMP);
  assign ramp_done       = done_r;

`ifdef PWM_RAMP_STATUS_EN
  logic sticky_r;

  // Sticky done flag; a new done pulse beats a simultaneous status read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (done_r) begin
      sticky_r <= 1'b1;
    end else if (rd_addr == ADDR_STATUS) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  // Combinational readback mux.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_EN_OUT_LO: rd_data = en_out_lo_r;
      ADDR_EN_OUT_HI: rd_data = en_out_hi_r;
      ADDR_EN_PWM_LO: rd_data = en_pwm_lo_r;
      ADDR_EN_PWM_HI: rd_data = en_pwm_hi_r;
      ADDR_DUTY:      rd_data = 8'(duty_r);
      ADDR_TARGET:    rd_data = 8'(target_r);
      ADDR_STEP:      rd_data = 8'(step_r);
      ADDR_PRESCALE:  rd_data = 8'(prescale_r);
      ADDR_STATUS:    rd_data = status_byte(sticky_r, state_r == RAMP);
      default:        rd_data = 8'h00;
    endcase
  end
`endif

endmodule
